// File: rtl/qc_syndrome_check.sv
// QC-LDPC syndrome checker: accumulates H*c over GF(2), one Z-bit circulant block per beat,
// using per-column shift values from an external base-matrix ROM, and reports the result at frame end.
module qc_syndrome_check #(
    parameter int Z  = 27,
    parameter int NB = 24,
    parameter int MB = 6,
    parameter int SW = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sof,
    input  logic [Z-1:0]       in_data,
    output logic [4:0]         h_addr,
    input  logic [MB*SW-1:0]   h_data,
    output logic [MB*Z-1:0]    syndrome,
    output logic [7:0]         syn_weight,
    output logic               syn_ok,
    output logic               done
);

    localparam int SYN_W = MB * Z;
    localparam logic [SW-1:0] ZERO_BLK = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d;
    logic [4:0]         h_addr_q, h_addr_d;
    logic [Z-1:0]       data1_q, data1_d;
    logic               vld1_q, vld1_d;
    logic               clr1_q, clr1_d;
    logic [SYN_W-1:0]   acc_q, acc_d;
    logic [SYN_W-1:0]   syndrome_q, syndrome_d;
    logic [7:0]         syn_weight_q, syn_weight_d;
    logic               syn_ok_q, syn_ok_d;
    logic               done_q, done_d;
    logic               accept;
    logic [SW-1:0]      shift;

    // Right-rotate by s: bit i of the result is d[(i+s) mod Z] for s < Z.
    function automatic logic [Z-1:0] rotr(input logic [Z-1:0] d, input logic [SW-1:0] s);
        logic [2*Z-1:0] dd;
        dd = {d, d} >> s;
        return dd[Z-1:0];
    endfunction

    function automatic logic [7:0] popcnt(input logic [SYN_W-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int unsigned i = 0; i < SYN_W; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        h_addr_d     = h_addr_q;
        data1_d      = data1_q;
        vld1_d       = 1'b0;
        clr1_d       = 1'b0;
        syndrome_d   = syndrome_q;
        syn_weight_d = syn_weight_q;
        syn_ok_d     = syn_ok_q;
        done_d       = 1'b0;
        shift        = '0;

        // Stage 2: a restart clears the old partial sum before block 0 is folded in.
        acc_d = clr1_q ? '0 : acc_q;
        if (vld1_q) begin
            for (int unsigned r = 0; r < MB; r++) begin
                shift = h_data[r*SW +: SW];
                if (shift != ZERO_BLK) begin
                    acc_d[r*Z +: Z] = acc_d[r*Z +: Z] ^ rotr(data1_q, shift);
                end
            end
        end

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept && in_sof) begin
                    state_d  = ACCUM;
                    cnt_d    = 5'd1;
                    h_addr_d = '0;
                    data1_d  = in_data;
                    vld1_d   = 1'b1;
                    clr1_d   = 1'b1;
                end
            end
            ACCUM: begin
                if (accept) begin
                    vld1_d  = 1'b1;
                    data1_d = in_data;
                    if (in_sof) begin
                        cnt_d    = 5'd1;
                        h_addr_d = '0;
                        clr1_d   = 1'b1;
                    end else begin
                        h_addr_d = cnt_q;
                        cnt_d    = cnt_q + 5'd1;
                        if (cnt_q == 5'(NB - 1)) begin
                            state_d = FLUSH;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            FLUSH: begin
                syndrome_d   = acc_d;
                syn_weight_d = popcnt(acc_d);
                syn_ok_d     = (acc_d == '0);
                done_d       = 1'b1;
                state_d      = DONE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d != FLUSH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            h_addr_q     <= '0;
            data1_q      <= '0;
            vld1_q       <= 1'b0;
            clr1_q       <= 1'b0;
            acc_q        <= '0;
            syndrome_q   <= '0;
            syn_weight_q <= '0;
            syn_ok_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            h_addr_q     <= h_addr_d;
            data1_q      <= data1_d;
            vld1_q       <= vld1_d;
            clr1_q       <= clr1_d;
            acc_q        <= acc_d;
            syndrome_q   <= syndrome_d;
            syn_weight_q <= syn_weight_d;
            syn_ok_q     <= syn_ok_d;
            done_q       <= done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign h_addr     = h_addr_q;
    assign syndrome   = syndrome_q;
    assign syn_weight = syn_weight_q;
    assign syn_ok     = syn_ok_q;
    assign done       = done_q;

endmodule

// File: doc/qc_syndrome_check.md
Name: qc_syndrome_check

Overview:
- Receive-side companion to qc_encoder. Accepts a QC-LDPC codeword streamed one 27-bit circulant block per beat: 24 blocks, n=648, Z=27, 6 block rows, 162 parity checks.
- Accumulates the 162-bit syndrome H·c over GF(2), using shift values fetched from an external base-matrix ROM.
- At end of frame, reports the syndrome, its weight, and a pass/fail flag.
- Sits ahead of any future decoder as a frame validity check; also serves as the self-check for encoder benches.

Parameters:
- Z, 27, circulant size, equal to block width in bits.
- NB, 24, block columns per codeword, equal to beats per frame.
- MB, 6, block rows; syndrome width is MB*Z = 162.
- SW, 6, shift field width; all-ones value (63) marks a zero block.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  block can accept a beat.
- in_sof  in  1  beat is block 0 of a new frame.
- in_data  in  Z  codeword block, bit j = codeword bit (blk*Z + j).
- h_addr  out  5  base-matrix column index to ROM.
- h_data  in  MB*SW  ROM data, 1-cycle latency; field r = bits [r*SW +: SW] = shift for block row r.
- syndrome  out  MB*Z  final syndrome; bit r*Z+i = check r*Z+i.
- syn_weight  out  8  popcount of syndrome (0..162).
- syn_ok  out  1  syndrome == 0.
- done  out  1  one-cycle pulse; syndrome, syn_weight and syn_ok valid from this cycle.

Behaviour:
- Reset values: in_ready=0, h_addr=0, syndrome=0, syn_weight=0, syn_ok=0, done=0, state=IDLE, block count=0, accumulator=0. in_ready rises in the cycle after rst deasserts.
- Accept rule: beat accepted when in_valid && in_ready.
- FSM states: IDLE, ACCUM, FLUSH, DONE.
- IDLE:
  - in_ready=1.
  - Beats without in_sof are dropped.
  - An accepted in_sof beat clears the accumulator, sets the count to 1, moves to ACCUM.
- ACCUM:
  - in_ready=1.
  - Each accepted beat increments the count.
  - The beat with count NB-1 (the 24th beat) moves to FLUSH.
  - Gaps (in_valid=0) are allowed and stall the count.
- Mid-frame restart: in_sof accepted in ACCUM discards the partial syndrome and restarts as block 0; the count resets to 1.
- Pipeline, stage 1:
  - On an accepted beat, h_addr = block index, registered.
  - in_data and a valid bit are registered alongside, so they align with h_data one cycle later.
- Pipeline, stage 2: for each r in 0..MB-1 with s = h_data field r:
  - If s == 63, no contribution.
  - Otherwise, for i in 0..Z-1: acc[r*Z+i] ^= d[(i+s) mod Z].
  - This is a right-rotate of d by s. Required range is s in 0..Z-1; values Z..62 are illegal and give undefined results.
  - Restart clears the accumulator before the stage-2 update of the new block 0 is applied, so block 0's contribution is never lost.
- FLUSH:
  - in_ready=0.
  - Waits one cycle for stage 2 to absorb the final block.
  - Then latches syndrome, syn_weight and syn_ok; done=1; moves to DONE.
- Latency: last beat accepted at cycle t gives done=1 at cycle t+2.
- DONE:
  - Held for one cycle with in_ready=1, then IDLE.
  - An in_sof beat accepted in DONE starts a new frame directly (back-to-back frames).
- Output hold: syndrome, syn_weight and syn_ok hold until the next done. They are not cleared at frame start.
- syn_weight is computed combinationally from the accumulator and registered at the done latch, so it is in step with syndrome.
- Async reset mid-frame: returns all state and outputs to reset values immediately, and the partial frame is lost.

Test Plan:
- Production ROM (802.11n R=3/4, Z=27), all-zero codeword, 24 back-to-back beats: done at t+2, syn_ok=1, syn_weight=0.
- Production ROM, codeword = prbs_rom info blocks plus qc_encoder parity, 24 beats: syn_ok=1, syndrome=0.
- Test ROM (only row0/col0 shift=3, all others 63), block 0 = bit 5 set, other blocks zero: syndrome bit 2 =1, syn_weight=1, syn_ok=0.
- Same test ROM, shift=26 (wrap-around), block 0 bit 0 set: syndrome bit 1 =1, syn_weight=1.
- Production ROM, valid codeword but in_valid deasserted 3 cycles after beat 10, and in_sof re-asserted at beat 15 followed by a full valid frame: exactly one done, syn_ok=1. Second frame sent back-to-back from DONE: done asserted 24 accepted beats + 2 cycles later.
- rst pulsed low at beat 12: done never asserted, outputs at reset values. A following full valid frame then gives syn_ok=1.
